// File: rtl/des_salt_key_sched.sv
// DES subkey scheduler feeding the salted E-XOR round stage: streams {salt, Kn} for ITERATIONS passes.
// Define KSCHED_DECRYPT_EN to emit K16..K1 per pass instead of K1..K16.
module des_salt_key_sched #(
  parameter int ITERATIONS = 25
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        LOAD,
  input  logic [55:0] KEY,
  input  logic [11:0] SALT,
  output logic [59:0] Y,
  output logic        Y_VALID,
  input  logic        Y_READY,
  output logic [3:0]  ROUND,
  output logic [4:0]  ITER,
  output logic        LAST,
  output logic        BUSY
);

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // bit i set where the encryption shift before K(i+1) is 2 rather than 1
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [55:0] pc1(input logic [55:0] k7);
    logic [63:0] k;
    logic [55:0] r;
    for (int i = 0; i < 8; i++) k[63-8*i -: 8] = {k7[55-7*i -: 7], 1'b0};
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] r;
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

`ifdef KSCHED_DECRYPT_EN
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
`endif

  state_t      state, state_nx;
  logic [27:0] c_q, d_q, c_nx, d_nx, c_rot, d_rot;
  logic [55:0] cd_ld;
  logic [11:0] salt_q;
  logic        start, xfer;

  assign start = (state == IDLE) && LOAD;
  assign xfer  = Y_VALID && Y_READY;
  assign LAST  = (state == EMIT) && (ROUND == 4'd15) && (ITER == 5'(ITERATIONS - 1));

  // FSM: state register
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (LOAD) state_nx = EMIT;
      EMIT:    if (xfer && LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    BUSY    = (state == EMIT);
    Y_VALID = (state == EMIT);
  end

  // Rotation data is independent of Y_READY; the handshake only reaches the enables.
  assign cd_ld = pc1(KEY);
  always_comb begin
`ifdef KSCHED_DECRYPT_EN
    c_rot = rotr(c_q, SHIFT2[~ROUND]);
    d_rot = rotr(d_q, SHIFT2[~ROUND]);
    c_nx  = start ? cd_ld[55:28] : c_rot;
    d_nx  = start ? cd_ld[27:0]  : d_rot;
`else
    c_rot = rotl(c_q, SHIFT2[ROUND + 4'd1]);
    d_rot = rotl(d_q, SHIFT2[ROUND + 4'd1]);
    c_nx  = start ? rotl(cd_ld[55:28], SHIFT2[0]) : c_rot;
    d_nx  = start ? rotl(cd_ld[27:0],  SHIFT2[0]) : d_rot;
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      c_q    <= '0;
      d_q    <= '0;
      salt_q <= '0;
      Y      <= '0;
    end else if (start || xfer) begin
      c_q <= c_nx;
      d_q <= d_nx;
      Y   <= {start ? SALT : salt_q, pc2(c_nx, d_nx)};
      if (start) salt_q <= SALT;
    end

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      ROUND <= '0;
      ITER  <= '0;
    end else if (start || (xfer && LAST)) begin
      ROUND <= '0;
      ITER  <= '0;
    end else if (xfer) begin
      ROUND <= ROUND + 4'd1;
      if (ROUND == 4'd15) ITER <= ITER + 5'd1;
    end

endmodule

// File: tb/tb_des_salt_key_sched.sv
// Scoreboard bench for des_salt_key_sched: FIPS and zero-key jobs, backpressure, LOAD-while-busy, mid-job reset.
module tb_des_salt_key_sched;
  localparam int NIT = 25;
`ifdef KSCHED_DECRYPT_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  localparam logic [47:0] KT [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
  localparam logic [55:0] FKEY = {7'h09, 7'h1A, 7'h2B, 7'h3C, 7'h4D, 7'h5E, 7'h6F, 7'h78};

  typedef struct packed {
    logic [59:0] y;
    logic [3:0]  r;
    logic [4:0]  it;
    logic        last;
  } exp_t;

  logic        CLK = 1'b0, RESET_N = 1'b0, LOAD = 1'b0, Y_READY = 1'b0;
  logic [55:0] KEY = '0;
  logic [11:0] SALT = '0;
  logic [59:0] Y;
  logic        Y_VALID, LAST, BUSY;
  logic [3:0]  ROUND;
  logic [4:0]  ITER;

  exp_t q[$];
  int   tests = 0, fails = 0;

  des_salt_key_sched #(.ITERATIONS(NIT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .LOAD(LOAD), .KEY(KEY), .SALT(SALT),
    .Y(Y), .Y_VALID(Y_VALID), .Y_READY(Y_READY), .ROUND(ROUND), .ITER(ITER),
    .LAST(LAST), .BUSY(BUSY));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: pop on every transfer, and require outputs to hold across stalls
  logic        stall_pend = 1'b0;
  logic [68:0] held;
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET_N) stall_pend = 1'b0;
    else begin
      if (stall_pend && Y_VALID) check("stall_hold", {Y, ROUND, ITER, LAST}, held);
      if (Y_VALID && Y_READY) begin
        if (q.size() == 0) check("unexpected_word", {4'h0, Y}, 64'h0);
        else begin
          e = q.pop_front();
          check("word_y", {4'h0, Y}, {4'h0, e.y});
          check("word_tag", {ROUND, ITER, LAST}, {e.r, e.it, e.last});
        end
      end
      stall_pend = Y_VALID && !Y_READY;
      held = {Y, ROUND, ITER, LAST};
    end
  end

  // called just after a posedge; returns just after the posedge that samples LOAD
  task automatic do_load(input bit fips, input logic [11:0] salt);
    exp_t e;
    KEY  = fips ? FKEY : 56'h0;
    SALT = salt;
    LOAD = 1'b1;
    for (int it = 0; it < NIT; it++)
      for (int r = 0; r < 16; r++) begin
        e.y    = {salt, fips ? KT[DEC ? 15 - r : r] : 48'h0};
        e.r    = 4'(r);
        e.it   = 5'(it);
        e.last = (it == NIT - 1) && (r == 15);
        q.push_back(e);
      end
    @(negedge CLK);
    check("idle_before_load", {63'h0, BUSY}, 64'h0);
    @(posedge CLK); #1;
    LOAD = 1'b0;
    check("load_latency", {53'h0, Y_VALID, BUSY, ROUND, ITER}, {53'h0, 1'b1, 1'b1, 4'h0, 5'h0});
  endtask

  // runs to the final transfer; returns just after the edge that takes it
  task automatic drain(input bit rnd, input int mid_at);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 3000) begin
      Y_READY = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (n == mid_at) begin
        LOAD = 1'b1; KEY = 56'h0; SALT = 12'hFFF;
      end else LOAD = 1'b0;
      @(negedge CLK);
      done = Y_VALID && Y_READY && LAST;
      @(posedge CLK); #1;
      n++;
    end
    LOAD = 1'b0;
    check("job_end_seen", {63'h0, done}, 64'h1);
  endtask

  initial begin
    bit hit = 1'b0;
    #7;
    check("rst_y", {4'h0, Y}, 64'h0);
    check("rst_flags", {59'h0, Y_VALID, LAST, BUSY, ROUND == 4'h0, ITER == 5'h0}, {59'h0, 5'b00011});
    @(negedge CLK); RESET_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("idle_after_rst", {62'h0, BUSY, Y_VALID}, 64'h0);
    Y_READY = 1'b1;

    do_load(1'b1, 12'h000);           // FIPS, full rate
    drain(1'b0, -1);
    do_load(1'b1, 12'h5A5);           // FIPS, backpressure, LOAD while busy
    drain(1'b1, 37);
    do_load(1'b0, 12'hABC);           // zero key, chained on the cycle after LAST
    drain(1'b0, -1);
    do_load(1'b1, 12'h123);           // mid-job reset

    for (int n = 0; n < 200 && !hit; n++) begin
      Y_READY = 1'b1;
      @(negedge CLK);
      hit = (ROUND == 4'd5) && (ITER == 5'd3);
      if (!hit) begin @(posedge CLK); #1; end
    end
    check("reached_r5_i3", {63'h0, hit}, 64'h1);
    #2 RESET_N = 1'b0;
    #1;
    check("midrst_y", {4'h0, Y}, 64'h0);
    check("midrst_flags", {53'h0, Y_VALID, LAST, BUSY, ROUND, ITER}, 64'h0);
    q.delete();
    @(posedge CLK);
    @(negedge CLK); #1 RESET_N = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("idle_after_midrst", {62'h0, BUSY, Y_VALID}, 64'h0);
    end
    check("queue_drained", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
